// File: rtl/mdu_controller_if.sv
// Pipeline-to-MDU signal bundle: operation request, MT/MF strobes and HI/LO results.
interface mdu_controller_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hilo_rd;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, src_a, src_b, hilo_rd, wr_hi, wr_lo, wdata, flush,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, src_a, src_b, hilo_rd, wr_hi, wr_lo, wdata, flush,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/mdu_controller.sv
// Iterative multiply/divide sequencer owning HI/LO; optional MUL early-out under MDU_EARLY_OUT_EN.
//  state | meaning
//  IDLE  | no operation in progress, MT writes allowed
//  MUL   | one shift-add step per cycle
//  DIV   | one restoring-divide step per cycle
//  FIX   | sign correction and HI/LO writeback
module mdu_controller #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    mdu_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;      // product, or {remainder, quotient}
    logic [2*WIDTH-1:0]   mcand;    // multiplicand, shifted left each step
    logic [WIDTH-1:0]     mplier;   // multiplier (shifted right) or divisor magnitude
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q;

    logic                 accept, div_zero, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   mul_sum, prod_fix;
    logic [WIDTH:0]       r_sh, diff;
    logic [WIDTH-1:0]     q_fix, r_fix;

    always_comb begin
        accept   = (state == IDLE) && bus.start && !bus.flush;
        div_zero = bus.op[1] && (bus.src_b == '0);
        a_neg    = bus.op[0] && bus.src_a[WIDTH-1];
        b_neg    = bus.op[0] && bus.src_b[WIDTH-1];
        a_mag    = a_neg ? -bus.src_a : bus.src_a;
        b_mag    = b_neg ? -bus.src_b : bus.src_b;
        mul_sum  = mplier[0] ? acc + mcand : acc;
        r_sh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = r_sh - {1'b0, mplier};
        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = bus.op[1] ? (div_zero ? FIX : DIV) : MUL;
            MUL: begin
                if (cnt == CNT_W'(1)) state_nx = FIX;
`ifdef MDU_EARLY_OUT_EN
                if (mplier[WIDTH-1:1] == '0) state_nx = FIX;
`endif
            end
            DIV:     if (cnt == CNT_W'(1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_hi) hi_q <= bus.wdata;
                    if (bus.wr_lo) lo_q <= bus.wdata;
                    if (accept) begin
                        cnt    <= CNT_W'(WIDTH);
                        is_div <= bus.op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        mplier <= b_mag;
                        if (!bus.op[1]) begin
                            acc   <= '0;
                            mcand <= {{WIDTH{1'b0}}, a_mag};
                        end else if (div_zero) begin
                            // FIX writes acc through unchanged: hi=dividend, lo=all ones
                            acc   <= {bus.src_a, {WIDTH{1'b1}}};
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            acc <= {{WIDTH{1'b0}}, a_mag};
                        end
                    end
                end
                MUL: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                end
                DIV: begin
                    cnt <= cnt - CNT_W'(1);
                    if (!diff[WIDTH]) acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    else              acc <= {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                end
                FIX: begin
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        if (is_div) begin
                            lo_q <= q_fix;
                            hi_q <= r_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state != IDLE);
    assign bus.stall = bus.busy & (bus.start | bus.hilo_rd | bus.wr_hi | bus.wr_lo);
endmodule

// File: tb/tb_mdu_controller.sv
// Directed-vector bench for mdu_controller: results, latency, stall, flush and reset.
module tb_mdu_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mdu_controller_if #(.WIDTH(32)) bus ();

    mdu_controller #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

`ifdef MDU_EARLY_OUT_EN
    localparam int LAT_5X3 = 3;
`else
    localparam int LAT_5X3 = 33;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
        bus.hilo_rd = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        bus.wdata = '0; bus.flush = 1'b0;
    endtask

    // Accept on E0, then count edges until done is seen; busy counted on the way.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_lat, input bit with_mt);
        int n, bc;
        bit got;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        if (with_mt) begin bus.wr_hi = 1'b1; bus.wdata = 32'hDEADBEEF; end
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.wr_hi = 1'b0;
        if (with_mt) check({tag, "_mt_hi"}, 64'(bus.hi), 64'hDEADBEEF);
        n = 0; bc = 0; got = 1'b0;
        while (n < 100 && !got) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
            else begin
                if (bus.busy) bc++;
                @(posedge clk);
                n++;
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    initial begin
        int errs, dones;
        idle_inputs();
        #12;
        check("rst_hi", 64'(bus.hi), 64'h0);
        check("rst_lo", 64'(bus.lo), 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_done", 64'(bus.done), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult_m3x7",  2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0);
        run_op("multu_max",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0);
        run_op("divs_m7d2",  2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
        run_op("divu_zero",  2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1,  1'b0);
        run_op("divs_wrap",  2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0);
        run_op("divu_100d7", 2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b0);
        run_op("multu_5x3",  2'b00, 32'd5,        32'd3,        32'd0,        32'h0000000F, LAT_5X3, 1'b0);
        run_op("mt_accept",  2'b00, 32'd2,        32'd3,        32'd0,        32'd6,        33, 1'b1);

        // stall while a dependent MFHI/MFLO and a second mul/div wait in EX
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd6; bus.src_b = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        errs = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 5) bus.hilo_rd = 1'b1;
            if (k == 10) begin bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 1; bus.src_b = 1; end
            if (k == 12) bus.start = 1'b0;
            #1;
            if (bus.stall !== (k >= 5)) errs++;
            if (bus.done !== 1'b0) errs++;
        end
        check("stall_window", 64'(errs), 64'd0);
        @(negedge clk);
        #1;
        check("stall_done_done", 64'(bus.done), 64'd1);
        check("stall_done_cycle", 64'(bus.stall), 64'd0);
        check("stall_lo", 64'(bus.lo), 64'h2A);
        bus.hilo_rd = 1'b0;
        @(negedge clk);
        check("second_start_ignored", 64'(bus.busy), 64'd0);

        // MT preload then flush mid-multiply
        bus.wr_hi = 1'b1; bus.wdata = 32'hAAAA5555;
        @(negedge clk);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wdata = 32'h12345678;
        @(negedge clk);
        bus.wr_lo = 1'b0;
        check("mthi", 64'(bus.hi), 64'hAAAA5555);
        check("mtlo", 64'(bus.lo), 64'h12345678);
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd6; bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("flush_no_done", 64'(dones), 64'd0);
        check("flush_hi", 64'(bus.hi), 64'hAAAA5555);
        check("flush_lo", 64'(bus.lo), 64'h12345678);

        // asynchronous reset mid-operation
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd6; bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hi", 64'(bus.hi), 64'h0);
        check("arst_lo", 64'(bus.lo), 64'h0);
        check("arst_busy", 64'(bus.busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_done", 64'(bus.done), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mdu_controller.md
Name: mdu_controller

Overview:
Sequencer and state owner for an iterative multiply/divide unit serving the pipeline's EX stage. It accepts MULT/MULTU/DIV/DIVU operations, runs a 32-step shift-add or restoring-divide datapath, and owns the HI/LO registers. It raises a stall request that the hazard logic ANDs into the PC, IF/ID and ID/EX write enables while a dependent instruction must wait.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  EX-stage instruction is a mul/div; sampled on the rising edge
op  in  2  00=MULTU 01=MULT 10=DIVU 11=DIVS
src_a  in  WIDTH  forwarded rs value; multiplicand or dividend
src_b  in  WIDTH  forwarded rt value; multiplier or divisor
hilo_rd  in  1  EX-stage instruction is MFHI/MFLO
wr_hi  in  1  MTHI write strobe
wr_lo  in  1  MTLO write strobe
wdata  in  WIDTH  MTHI/MTLO data
flush  in  1  cancel the in-flight operation
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  operation in progress
done  out  1  one-cycle pulse when HI/LO receive a result
stall  out  1  pipeline hold request

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi, lo, counter and internal accumulators = 0; busy=0; done=0.
- States:
  - IDLE: no operation in progress.
  - MUL: iterative multiply.
  - DIV: iterative divide.
  - FIX: sign correction and HI/LO writeback.
- Accept: in IDLE with start=1, on the clock edge:
  - For signed ops, latch operand magnitudes and the result sign: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Load counter = WIDTH.
  - Go to MUL or DIV.
- MUL: each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half of the 64-bit accumulator; then shift right 1. Decrement the counter; at 0 go to FIX.
- DIV: restoring division, one quotient bit per cycle. Shift {rem,quot} left 1; trial-subtract the divisor magnitude; keep the difference if it is ≥0 and set quot[0]. Decrement the counter; at 0 go to FIX.
- FIX: apply two's-complement negation where the result sign requires it.
  - MUL: hi = product[63:32], lo = product[31:0].
  - DIV: lo = quotient, hi = remainder.
  - Go to IDLE with done=1 for exactly that cycle.
- Latency: accept edge E0; iterations on edges E1..E32; FIX writeback on E33. busy=1 from after E0 until E33. done=1 in the cycle after E33.
- Divide by zero (src_b=0 at accept): skip DIV and go straight to FIX; lo=FFFFFFFF, hi=src_a; done after E1.
- DIVS 80000000 / FFFFFFFF: lo=80000000, hi=0. This is the natural wrap; no trap.
- stall = busy & (start | hilo_rd | wr_hi | wr_lo). It is combinational and deasserts in the done cycle.
- start while busy: ignored (not re-accepted); stall holds the instruction in EX until IDLE.
- wr_hi/wr_lo: take effect only in IDLE, on the edge.
  - If start is accepted on the same edge, the MT write still lands.
  - The later FIX result overwrites it.
- hi/lo never change during MUL/DIV; they update only at FIX, on MT writes, or at reset.
- flush=1: any state goes to IDLE next edge; hi/lo unchanged; no done pulse.
  - flush overrides start on the same edge: nothing is accepted.
- Reset asserted mid-operation: immediate return to the reset values; no partial result is written.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: in MUL, when the remaining shifted multiplier magnitude is 0, go to FIX on the next edge regardless of the counter; the product is identical. Example: 5×3 finishes at E3 instead of E33.
- Undefined: every multiply takes exactly 32 iterations. DIV timing is unaffected either way.

Test Plan:
1. MULT src_a=FFFFFFFD (-3), src_b=00000007 → hi=FFFFFFFF, lo=FFFFFFEB; done exactly 34 cycles after the accept cycle; busy high 33 cycles.
2. MULTU FFFFFFFF×FFFFFFFF → hi=FFFFFFFE, lo=00000001. DIVS FFFFFFF9 (-7) / 00000002 → lo=FFFFFFFD, hi=FFFFFFFF.
3. DIVU 00001234 / 0 → lo=FFFFFFFF, hi=00001234, done one cycle after accept. DIVS 80000000/FFFFFFFF → lo=80000000, hi=0.
4. Accept MULT 6×7, then hilo_rd=1 at cycle 5 → stall=1 through cycle 33, stall=0 in the done cycle, lo=0000002A; a second start during busy is not accepted.
5. flush at iteration 10 with hi/lo preloaded via MTHI=AAAA5555, MTLO=12345678 → state IDLE, no done, hi/lo unchanged. Separately, reset low at iteration 20 → hi=lo=0, busy=0 immediately.
6. With MDU_EARLY_OUT_EN: MULTU 5×3 → lo=0000000F, hi=0, done 4 cycles after accept. Without it → same values, done after 34 cycles.
